pr_ring_scheduler: RTL and testbench

//  Next-gen PageRank scheduler. Accepts config/start commands on the test source/sink interface.

---
 rtl/pr_ring_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_pr_ring_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_ring_scheduler.sv
// Ring-graph PageRank scheduler: loads a rank vector over striped memory ports, iterates on-chip, stores it back.
// Optional early exit on convergence is built when PR_SCHED_CONVERGE_EN is defined.
module pr_ring_scheduler #(
    parameter int          nbits    = 32,
    parameter int          nports   = 2,
    parameter int          NNODES   = 8,
    parameter logic [31:0] TELEPORT = 32'h100,
    localparam int         REQ_W    = 77,
    localparam int         RESP_W   = 47
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_req_val,
    output logic                     in_req_rdy,
    input  logic                     in_req_type,
    input  logic [31:0]              in_req_addr,
    input  logic [nbits-1:0]         in_req_data,
    output logic                     out_resp_val,
    input  logic                     out_resp_rdy,
    output logic                     out_resp_type,
    output logic [nbits-1:0]         out_resp_data,
    output logic [nports-1:0]        mem_req_val,
    input  logic [nports-1:0]        mem_req_rdy,
    output logic [nports*REQ_W-1:0]  mem_req_msg,
    input  logic [nports-1:0]        mem_resp_val,
    output logic [nports-1:0]        mem_resp_rdy,
    input  logic [nports*RESP_W-1:0] mem_resp_msg,
    output logic [2:0]               dbg_state
);

    // Handshake: a transfer happens on a rising edge where val && rdy; a held val keeps its msg stable.
    // Memory message layouts (MSB first):
    //   request  {type[2:0], opaque[7:0], addr[31:0], len[1:0], data[31:0]}
    //   response {type[2:0], opaque[7:0], test[1:0], len[1:0], data[31:0]}
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CFG   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [2:0] MEM_READ  = 3'd0;
    localparam logic [2:0] MEM_WRITE = 3'd1;

    localparam int IW = (NNODES > 1) ? $clog2(NNODES) : 1;
    localparam int EW = $clog2(NNODES + nports) + 1;
    localparam int CW = $clog2(NNODES + nports + 1) + 1;

    localparam logic [EW-1:0]    NN_E   = EW'(NNODES);
    localparam logic [EW-1:0]    NP_E   = EW'(nports);
    localparam logic [CW-1:0]    NN_C   = CW'(NNODES);
    localparam logic [8:0]       NN_OP  = 9'(NNODES);
    localparam logic [nbits-1:0] TELE   = TELEPORT[nbits-1:0];

    logic [2:0]       state_q, state_d;
    logic [nbits-1:0] src_q, src_d;
    logic [nbits-1:0] dst_q, dst_d;
    logic [nbits-1:0] iters_q, iters_d;
    logic [nbits-1:0] iter_cnt_q, iter_cnt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [EW-1:0]    elem_q [nports];
    logic [EW-1:0]    elem_d [nports];
    logic [nbits-1:0] rank_q [NNODES];
    logic [nbits-1:0] rank_d [NNODES];
    logic [nbits-1:0] rank_next [NNODES];

    logic [7:0]       resp_op   [nports];
    logic [nbits-1:0] resp_data [nports];
    logic [CW-1:0]    resp_pop;
    logic             busy;
    logic             is_store;
    logic             converged;
    logic             unused_resp;

    assign busy         = (state_q == S_LOAD) || (state_q == S_STORE);
    assign is_store     = (state_q == S_STORE);
    assign unused_resp  = ^mem_resp_msg;
    assign mem_resp_rdy = '1;
    assign dbg_state    = state_q;

    assign in_req_rdy    = (state_q == S_IDLE);
    assign out_resp_val  = (state_q == S_CFG) || (state_q == S_DONE);
    assign out_resp_type = (state_q == S_DONE);
    assign out_resp_data = (state_q == S_DONE) ? iter_cnt_q : '0;

    // Port p walks elements p, p+nports, ... ; its cursor is the next element index it will issue.
    always_comb begin
        mem_req_val = '0;
        mem_req_msg = '0;
        for (int p = 0; p < nports; p++) begin
            mem_req_val[p] = busy && (elem_q[p] < NN_E);
            mem_req_msg[p*REQ_W +: REQ_W] = {
                is_store ? MEM_WRITE : MEM_READ,
                8'(elem_q[p]),
                32'(is_store ? dst_q : src_q) + {30'(elem_q[p]), 2'b00},
                2'b00,
                is_store ? 32'(rank_q[elem_q[p][IW-1:0]]) : 32'd0
            };
        end
    end

    always_comb begin
        resp_pop = '0;
        for (int p = 0; p < nports; p++) begin
            resp_op[p]   = mem_resp_msg[p*RESP_W + 36 +: 8];
            resp_data[p] = mem_resp_msg[p*RESP_W +: nbits];
            resp_pop     = resp_pop + {{(CW-1){1'b0}}, mem_resp_val[p]};
        end
    end

    always_comb begin
        for (int i = 0; i < NNODES; i++) begin
            rank_next[i] = TELE + (rank_q[(i + NNODES - 1) % NNODES] >> 1);
        end
    end

`ifdef PR_SCHED_CONVERGE_EN
    always_comb begin
        converged = 1'b1;
        for (int i = 0; i < NNODES; i++) begin
            if (rank_next[i] != rank_q[i]) converged = 1'b0;
        end
    end
`else
    assign converged = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        iters_d    = iters_q;
        iter_cnt_d = iter_cnt_q;
        cnt_d      = cnt_q;
        elem_d     = elem_q;
        rank_d     = rank_q;
        case (state_q)
            S_IDLE: begin
                if (in_req_val) begin
                    if (!in_req_type) begin
                        state_d = S_CFG;
                        if (in_req_addr == 32'd0)      src_d   = in_req_data;
                        else if (in_req_addr == 32'd1) dst_d   = in_req_data;
                        else if (in_req_addr == 32'd2) iters_d = in_req_data;
                    end else begin
                        state_d    = S_LOAD;
                        cnt_d      = '0;
                        iter_cnt_d = '0;
                        for (int p = 0; p < nports; p++) elem_d[p] = EW'(p);
                    end
                end
            end
            S_CFG: begin
                if (out_resp_rdy) state_d = S_IDLE;
            end
            S_LOAD: begin
                for (int p = 0; p < nports; p++) begin
                    if (mem_req_val[p] && mem_req_rdy[p]) elem_d[p] = elem_q[p] + NP_E;
                    if (mem_resp_val[p] && ({1'b0, resp_op[p]} < NN_OP)) begin
                        rank_d[resp_op[p][IW-1:0]] = resp_data[p];
                    end
                end
                cnt_d = cnt_q + resp_pop;
                if (cnt_d == NN_C) begin
                    if (iters_q == '0) begin
                        state_d = S_STORE;
                        cnt_d   = '0;
                        for (int p = 0; p < nports; p++) elem_d[p] = EW'(p);
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rank_d     = rank_next;
                iter_cnt_d = iter_cnt_q + 1'b1;
                if ((iter_cnt_d == iters_q) || converged) begin
                    state_d = S_STORE;
                    cnt_d   = '0;
                    for (int p = 0; p < nports; p++) elem_d[p] = EW'(p);
                end
            end
            S_STORE: begin
                for (int p = 0; p < nports; p++) begin
                    if (mem_req_val[p] && mem_req_rdy[p]) elem_d[p] = elem_q[p] + NP_E;
                end
                cnt_d = cnt_q + resp_pop;
                if (cnt_d == NN_C) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_resp_rdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            iters_q    <= '0;
            iter_cnt_q <= '0;
            cnt_q      <= '0;
            for (int p = 0; p < nports; p++) elem_q[p] <= '0;
            for (int i = 0; i < NNODES; i++) rank_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            iters_q    <= iters_d;
            iter_cnt_q <= iter_cnt_d;
            cnt_q      <= cnt_d;
            elem_q     <= elem_d;
            rank_q     <= rank_d;
        end
    end

endmodule

// File: tb/tb_pr_ring_scheduler.sv
// Directed + randomized bench for pr_ring_scheduler with a behavioural memory and PageRank model.
module tb_pr_ring_scheduler;

    localparam int NB     = 32;
    localparam int NP     = 2;
    localparam int NN     = 8;
    localparam int REQ_W  = 77;
    localparam int RESP_W = 47;
    localparam logic [31:0] TELE = 32'h100;

    logic                   clk;
    logic                   rst;
    logic                   in_req_val;
    logic                   in_req_rdy;
    logic                   in_req_type;
    logic [31:0]            in_req_addr;
    logic [NB-1:0]          in_req_data;
    logic                   out_resp_val;
    logic                   out_resp_rdy;
    logic                   out_resp_type;
    logic [NB-1:0]          out_resp_data;
    logic [NP-1:0]          mem_req_val;
    logic [NP-1:0]          mem_req_rdy;
    logic [NP*REQ_W-1:0]    mem_req_msg;
    logic [NP-1:0]          mem_resp_val;
    logic [NP-1:0]          mem_resp_rdy;
    logic [NP*RESP_W-1:0]   mem_resp_msg;
    logic [2:0]             dbg_state;

    int checks = 0;
    int failures = 0;
    int stall_pct = 0;
    int write_cnt = 0;

    logic [31:0] mem [logic [31:0]];
    logic [RESP_W+3:0] rq [$];
    logic [31:0] exp_q [$];

    pr_ring_scheduler #(.nbits(NB), .nports(NP), .NNODES(NN), .TELEPORT(TELE)) dut (
        .clk(clk), .reset(rst),
        .in_req_val(in_req_val), .in_req_rdy(in_req_rdy), .in_req_type(in_req_type),
        .in_req_addr(in_req_addr), .in_req_data(in_req_data),
        .out_resp_val(out_resp_val), .out_resp_rdy(out_resp_rdy),
        .out_resp_type(out_resp_type), .out_resp_data(out_resp_data),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: per-port in-order responses, random stalls, responses no earlier than the next cycle.
    initial begin
        logic [REQ_W-1:0] req;
        logic [31:0] rd;
        int idx;
        mem_req_rdy  = '0;
        mem_resp_val = '0;
        mem_resp_msg = '0;
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                idx = -1;
                for (int k = 0; k < rq.size(); k++) begin
                    if (idx < 0 && rq[k][RESP_W+3:RESP_W] == 4'(p)) idx = k;
                end
                if (idx >= 0 && $urandom_range(99) >= stall_pct) begin
                    mem_resp_val[p] = 1'b1;
                    mem_resp_msg[p*RESP_W +: RESP_W] = rq[idx][RESP_W-1:0];
                    rq.delete(idx);
                end else begin
                    mem_resp_val[p] = 1'b0;
                    mem_resp_msg[p*RESP_W +: RESP_W] = '0;
                end
                mem_req_rdy[p] = ($urandom_range(99) >= stall_pct);
                if (!rst && mem_req_val[p] && mem_req_rdy[p]) begin
                    req = mem_req_msg[p*REQ_W +: REQ_W];
                    if (req[76:74] == 3'd1) begin
                        mem[req[65:34]] = req[31:0];
                        write_cnt++;
                        rq.push_back({4'(p), 3'd1, req[73:66], 4'd0, 32'd0});
                    end else begin
                        rd = mem.exists(req[65:34]) ? mem[req[65:34]] : 32'd0;
                        rq.push_back({4'(p), 3'd0, req[73:66], 4'd0, rd});
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: issue one command, wait for its response, report latency from accept to response.
    task automatic do_cmd(input logic typ, input logic [31:0] addr, input logic [31:0] data,
                          output logic rtype, output logic [31:0] rdata, output int lat,
                          output bit timeout);
        int w;
        @(negedge clk);
        in_req_val  = 1'b1;
        in_req_type = typ;
        in_req_addr = addr;
        in_req_data = data;
        w = 0;
        while (!in_req_rdy && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        in_req_val = 1'b0;
        lat = 0;
        while (!out_resp_val && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        timeout = !out_resp_val;
        rtype   = out_resp_type;
        rdata   = out_resp_data;
        @(posedge clk);
    endtask

    task automatic configure(input logic [31:0] src, input logic [31:0] dst, input int iters);
        logic rt;
        logic [31:0] rd;
        int lat;
        bit to;
        do_cmd(1'b0, 32'd0, src, rt, rd, lat, to);
        do_cmd(1'b0, 32'd1, dst, rt, rd, lat, to);
        do_cmd(1'b0, 32'd2, 32'(iters), rt, rd, lat, to);
    endtask

    // Reference model + scoreboard for one start command.
    task automatic run_case(input string tag, input logic [31:0] src, input logic [31:0] dst,
                            input int iters, input int stall);
        logic [31:0] cur [NN];
        logic [31:0] nxt [NN];
        int exp_its;
        bit same;
        logic rt;
        logic [31:0] rd;
        int lat;
        bit to;
        for (int i = 0; i < NN; i++) cur[i] = mem[src + 32'(4*i)];
        exp_its = 0;
        for (int k = 0; k < iters; k++) begin
            same = 1'b1;
            for (int i = 0; i < NN; i++) begin
                nxt[i] = TELE + (cur[(i + NN - 1) % NN] / 2);
                if (nxt[i] != cur[i]) same = 1'b0;
            end
            cur = nxt;
            exp_its++;
`ifdef PR_SCHED_CONVERGE_EN
            if (same) break;
`endif
        end
        for (int i = 0; i < NN; i++) exp_q.push_back(cur[i]);
        if (dst != src) begin
            for (int i = 0; i < NN; i++) mem[dst + 32'(4*i)] = 32'hdead_beef;
        end
        stall_pct = 0;
        configure(src, dst, iters);
        stall_pct = stall;
        write_cnt = 0;
        do_cmd(1'b1, 32'd0, 32'd0, rt, rd, lat, to);
        stall_pct = 0;
        check({tag, "_timeout"}, 32'(to), 32'd0);
        check({tag, "_type"}, 32'(rt), 32'd1);
        check({tag, "_iters"}, rd, 32'(exp_its));
        check({tag, "_writes"}, 32'(write_cnt), 32'(NN));
        for (int i = 0; i < NN; i++) begin
            check({tag, "_dst"}, mem[dst + 32'(4*i)], exp_q.pop_front());
        end
    endtask

    initial begin
        logic rt;
        logic [31:0] rd;
        int lat;
        bit to;
        int w;
        logic [31:0] rnd [NN];

        rst          = 1'b1;
        in_req_val   = 1'b0;
        in_req_type  = 1'b0;
        in_req_addr  = '0;
        in_req_data  = '0;
        out_resp_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_req_rdy", 32'(in_req_rdy), 32'd1);
        check("rst_out_resp_val", 32'(out_resp_val), 32'd0);
        check("rst_mem_req_val", 32'(mem_req_val), 32'd0);
        check("rst_mem_resp_rdy", 32'(mem_resp_rdy), 32'd3);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;

        // Config writes: response one cycle after accept, type 0, data 0.
        do_cmd(1'b0, 32'd0, 32'h1000, rt, rd, lat, to);
        check("cfg_src_lat", 32'(lat), 32'd0);
        check("cfg_src_type", 32'(rt), 32'd0);
        check("cfg_src_data", rd, 32'd0);
        do_cmd(1'b0, 32'd1, 32'h2000, rt, rd, lat, to);
        check("cfg_dst_lat", 32'(lat), 32'd0);
        check("cfg_dst_type", 32'(rt), 32'd0);
        check("cfg_dst_data", rd, 32'd0);
        do_cmd(1'b0, 32'd2, 32'd1, rt, rd, lat, to);
        check("cfg_iter_lat", 32'(lat), 32'd0);
        check("cfg_iter_type", 32'(rt), 32'd0);
        check("cfg_iter_data", rd, 32'd0);
        @(negedge clk);
        check("cfg_back_idle", 32'(in_req_rdy), 32'd1);

        // Uniform 0x800, one iteration.
        for (int i = 0; i < NN; i++) mem[32'h1000 + 32'(4*i)] = 32'h800;
        run_case("uniform", 32'h1000, 32'h2000, 1, 0);
        check("uniform_const", mem[32'h2000], 32'h500);

        // Zero iterations copies the vector.
        for (int i = 0; i < NN; i++) mem[32'h1000 + 32'(4*i)] = 32'(i);
        run_case("zero_iter", 32'h1000, 32'h2000, 0, 0);
        check("zero_iter_const", mem[32'h2000 + 32'd12], 32'd3);

        // Same random vector, unstalled then heavily stalled.
        for (int i = 0; i < NN; i++) begin
            rnd[i] = $urandom;
            mem[32'h3000 + 32'(4*i)] = rnd[i];
        end
        run_case("rand_nostall", 32'h3000, 32'h4000, 3, 0);
        for (int i = 0; i < NN; i++) mem[32'h3000 + 32'(4*i)] = rnd[i];
        run_case("rand_stall", 32'h3000, 32'h5000, 3, 60);

        // Fixed point 0x200.
        for (int i = 0; i < NN; i++) mem[32'h1000 + 32'(4*i)] = 32'h200;
        run_case("fixed", 32'h1000, 32'h2000, 10, 0);

        // Reset in the middle of LOAD, then a fresh run.
        for (int i = 0; i < NN; i++) mem[32'h6000 + 32'(4*i)] = $urandom;
        configure(32'h6000, 32'h7000, 2);
        stall_pct = 50;
        write_cnt = 0;
        @(negedge clk);
        in_req_val  = 1'b1;
        in_req_type = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_req_val = 1'b0;
        w = 0;
        while (mem_req_val == '0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("abort_load_seen", 32'(dbg_state), 32'd2);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("abort_rdy_in_rst", 32'(in_req_rdy), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_rdy_after", 32'(in_req_rdy), 32'd1);
        check("abort_mem_req_val", 32'(mem_req_val), 32'd0);
        stall_pct = 0;
        repeat (20) @(negedge clk);
        check("abort_no_writes", 32'(write_cnt), 32'd0);
        run_case("after_abort", 32'h6000, 32'h7000, 2, 30);

        // Randomized runs, including in-place src == dst.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < NN; i++) mem[32'h8000 + 32'(4*i)] = $urandom;
            run_case("rand_loop", 32'h8000, (t % 2 == 0) ? 32'h8000 : 32'h9000,
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 70)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
